// File: rtl/forwarding_hazard_ctrl_pkg.sv
// rtl/forwarding_hazard_ctrl_pkg.sv - shared encodings for the forwarding/hazard controller
package forwarding_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 4;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_RET     = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/forwarding_hazard_ctrl_fwd_operand_cmp.sv
// rtl/forwarding_hazard_ctrl_fwd_operand_cmp.sv - per-operand match against EX/WB producers
module fwd_operand_cmp
  import forwarding_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic              ex_v,
  input  logic              ex_wr,
  input  logic              ex_ld,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              wb_v,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic src_zero;
  logic match_ex;
  logic match_wb;

  assign src_zero = ZERO_REG && (src == '0);
  assign match_ex = used && ex_v && ex_wr && (src == ex_dest) && !src_zero;
  assign match_wb = used && wb_v && wb_wr && (src == wb_dest) && !src_zero;
  assign load_hit = match_ex && ex_ld;

  // The EX producer is younger than the WB one, so it wins.
  always_comb begin
    sel = FWD_REGFILE;
    if (match_ex) begin
      sel = FWD_WB;
    end else if (match_wb) begin
      sel = FWD_RET;
    end
  end

endmodule

// File: rtl/forwarding_hazard_ctrl.sv
// rtl/forwarding_hazard_ctrl.sv - in-flight dest tracking, operand forwarding selects and load-use stall
module forwarding_hazard_ctrl
  import forwarding_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int LOAD_STALL = 1,
  parameter bit ZERO_REG   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic              id_src_a_used,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic              id_src_b_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic [REG_AW-1:0] ex_dest,
  output logic [REG_AW-1:0] wb_dest,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);

  logic              ex_v_q, ex_v_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_wr_q, ex_wr_d;
  logic              ex_ld_q, ex_ld_d;
  logic              wb_v_q, wb_v_d;
  logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
  logic              wb_wr_q, wb_wr_d;
  logic [1:0]        fwd_sel_a_q, fwd_sel_a_d;
  logic [1:0]        fwd_sel_b_q, fwd_sel_b_d;
  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic [1:0] sel_a, sel_b;
  logic       hit_a, hit_b;
  logic       hazard;
  logic       id_go;

  fwd_operand_cmp #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_cmp_a (
    .src(id_src_a), .used(id_src_a_used),
    .ex_v(ex_v_q), .ex_wr(ex_wr_q), .ex_ld(ex_ld_q), .ex_dest(ex_dest_q),
    .wb_v(wb_v_q), .wb_wr(wb_wr_q), .wb_dest(wb_dest_q),
    .sel(sel_a), .load_hit(hit_a)
  );

  fwd_operand_cmp #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_cmp_b (
    .src(id_src_b), .used(id_src_b_used),
    .ex_v(ex_v_q), .ex_wr(ex_wr_q), .ex_ld(ex_ld_q), .ex_dest(ex_dest_q),
    .wb_v(wb_v_q), .wb_wr(wb_wr_q), .wb_dest(wb_dest_q),
    .sel(sel_b), .load_hit(hit_b)
  );

  // Both operands hitting the same load still yield a single stall sequence.
  assign hazard = id_valid && !flush && (hit_a || hit_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard && (LOAD_STALL > 1)) begin
            state_d = ST_STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
        ST_STALL: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_if_id = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_RUN:   stall_if_id = hazard;
        ST_STALL: stall_if_id = 1'b1;
        default:  stall_if_id = 1'b0;
      endcase
    end
  end

  assign id_go = id_valid && !flush && !stall_if_id;

  // Invalid entries carry dest 0 so ex_dest/wb_dest read 0 for bubbles.
  always_comb begin
    ex_v_d      = id_go;
    ex_dest_d   = id_go ? id_dest : '0;
    ex_wr_d     = id_go && id_wr_en;
    ex_ld_d     = id_go && id_is_load;
    wb_v_d      = ex_v_q;
    wb_dest_d   = ex_dest_q;
    wb_wr_d     = ex_wr_q;
    fwd_sel_a_d = id_go ? sel_a : FWD_REGFILE;
    fwd_sel_b_d = id_go ? sel_b : FWD_REGFILE;
    stall_cycles_d = stall_cycles_q;
    if (stall_if_id && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q         <= 1'b0;
      ex_dest_q      <= '0;
      ex_wr_q        <= 1'b0;
      ex_ld_q        <= 1'b0;
      wb_v_q         <= 1'b0;
      wb_dest_q      <= '0;
      wb_wr_q        <= 1'b0;
      fwd_sel_a_q    <= FWD_REGFILE;
      fwd_sel_b_q    <= FWD_REGFILE;
      stall_cycles_q <= '0;
    end else begin
      ex_v_q         <= ex_v_d;
      ex_dest_q      <= ex_dest_d;
      ex_wr_q        <= ex_wr_d;
      ex_ld_q        <= ex_ld_d;
      wb_v_q         <= wb_v_d;
      wb_dest_q      <= wb_dest_d;
      wb_wr_q        <= wb_wr_d;
      fwd_sel_a_q    <= fwd_sel_a_d;
      fwd_sel_b_q    <= fwd_sel_b_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fwd_sel_a    = fwd_sel_a_q;
  assign fwd_sel_b    = fwd_sel_b_q;
  assign bubble_ex    = !ex_v_q;
  assign ex_dest      = ex_dest_q;
  assign wb_dest      = wb_dest_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// tb/tb_forwarding_hazard_ctrl.sv - vector table and scoreboard bench for forwarding_hazard_ctrl
module tb_forwarding_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_src_a = '0;
  logic       id_src_a_used = 1'b0;
  logic [3:0] id_src_b = '0;
  logic       id_src_b_used = 1'b0;
  logic [3:0] id_dest = '0;
  logic       id_wr_en = 1'b0;
  logic       id_is_load = 1'b0;
  logic       flush = 1'b0;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        st1, st3, bub1, bub3;
  logic [3:0]  exd1, wbd1, exd3, wbd3;
  logic [15:0] sc1, sc3;

  always #5 clk = ~clk;

  forwarding_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(1), .ZERO_REG(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_a_used(id_src_a_used),
    .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
    .id_dest(id_dest), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_if_id(st1), .bubble_ex(bub1),
    .ex_dest(exd1), .wb_dest(wbd1), .stall_cycles(sc1)
  );

  forwarding_hazard_ctrl #(.REG_AW(4), .LOAD_STALL(3), .ZERO_REG(1'b1), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_a_used(id_src_a_used),
    .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
    .id_dest(id_dest), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel_a(fa3), .fwd_sel_b(fb3), .stall_if_id(st3), .bubble_ex(bub3),
    .ex_dest(exd3), .wb_dest(wbd3), .stall_cycles(sc3)
  );

  typedef struct {
    logic       v;
    logic [3:0] sa;
    logic       ua;
    logic [3:0] sb;
    logic       ub;
    logic [3:0] d;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic       e_bub;
    logic [3:0] e_exd;
    logic [3:0] e_wbd;
  } vec_t;

  typedef struct {
    int         which;
    int         tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       bub;
    logic [3:0] exd;
    logic [3:0] wbd;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[21];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic vec_t mk(int v, int sa, int ua, int sb, int ub, int d, int wr, int ld,
                              int fl, int st, int fa, int fb, int bub, int exd, int wbd);
    vec_t r;
    r.v = 1'(v);   r.sa = 4'(sa); r.ua = 1'(ua); r.sb = 4'(sb); r.ub = 1'(ub);
    r.d = 4'(d);   r.wr = 1'(wr); r.ld = 1'(ld); r.fl = 1'(fl);
    r.e_stall = 1'(st); r.e_fa = 2'(fa); r.e_fb = 2'(fb); r.e_bub = 1'(bub);
    r.e_exd = 4'(exd);  r.e_wbd = 4'(wbd);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input vec_t v, input int which, input int tag);
    exp_t e;
    id_valid = v.v; id_src_a = v.sa; id_src_a_used = v.ua;
    id_src_b = v.sb; id_src_b_used = v.ub; id_dest = v.d;
    id_wr_en = v.wr; id_is_load = v.ld; flush = v.fl;
    #1;
    chk($sformatf("d%0d/%0d stall_if_id", which, tag), which ? int'(st3) : int'(st1), int'(v.e_stall));
    sbq.push_back('{which, tag, v.e_fa, v.e_fb, v.e_bub, v.e_exd, v.e_wbd});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk($sformatf("d%0d/%0d fwd_sel_a", e.which, e.tag), e.which ? int'(fa3) : int'(fa1), int'(e.fa));
    chk($sformatf("d%0d/%0d fwd_sel_b", e.which, e.tag), e.which ? int'(fb3) : int'(fb1), int'(e.fb));
    chk($sformatf("d%0d/%0d bubble_ex", e.which, e.tag), e.which ? int'(bub3) : int'(bub1), int'(e.bub));
    chk($sformatf("d%0d/%0d ex_dest", e.which, e.tag), e.which ? int'(exd3) : int'(exd1), int'(e.exd));
    chk($sformatf("d%0d/%0d wb_dest", e.which, e.tag), e.which ? int'(wbd3) : int'(wbd1), int'(e.wbd));
  endtask

  task automatic reset_pulse();
    id_valid = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ALU chain, distance 2/3, write-disabled and unused operands, zero reg, load-use, flush
    tbl[0]  = mk(1, 0,0, 0,0,  3,1,0,0, 0, 0,0,0,  3, 0);
    tbl[1]  = mk(1, 3,1, 1,1,  4,1,0,0, 0, 1,0,0,  4, 3);
    tbl[2]  = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,0,1,  0, 4);
    tbl[3]  = mk(1, 0,0, 0,0,  5,1,0,0, 0, 0,0,0,  5, 0);
    tbl[4]  = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,0,1,  0, 5);
    tbl[5]  = mk(1, 6,1, 5,1,  8,0,0,0, 0, 0,2,0,  8, 0);
    tbl[6]  = mk(1, 8,1, 0,0,  9,1,0,0, 0, 0,0,0,  9, 8);
    tbl[7]  = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,0,1,  0, 9);
    tbl[8]  = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,0,1,  0, 0);
    tbl[9]  = mk(1, 0,0, 9,1, 10,1,0,0, 0, 0,0,0, 10, 0);
    tbl[10] = mk(1,10,0, 0,0,  0,1,0,0, 0, 0,0,0,  0,10);
    tbl[11] = mk(1, 0,1, 0,1,  7,1,0,0, 0, 0,0,0,  7, 0);
    tbl[12] = mk(1, 0,0, 0,0,  7,1,0,0, 0, 0,0,0,  7, 7);
    tbl[13] = mk(1, 7,1, 0,0, 11,1,0,0, 0, 1,0,0, 11, 7);
    tbl[14] = mk(1, 7,1,11,1, 11,1,0,0, 0, 2,1,0, 11,11);
    tbl[15] = mk(1, 0,0, 0,0,  2,1,1,0, 0, 0,0,0,  2,11);
    tbl[16] = mk(1, 2,1, 2,1,  4,1,0,0, 1, 0,0,1,  0, 2);
    tbl[17] = mk(1, 2,1, 2,1,  4,1,0,0, 0, 2,2,0,  4, 0);
    tbl[18] = mk(1, 0,0, 0,0,  6,1,1,0, 0, 0,0,0,  6, 4);
    tbl[19] = mk(1, 6,1, 0,0,  9,1,0,1, 0, 0,0,1,  0, 6);
    tbl[20] = mk(0, 0,0, 0,0,  0,0,0,0, 0, 0,0,1,  0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset fwd_sel_a", int'(fa1), 0);
    chk("reset fwd_sel_b", int'(fb1), 0);
    chk("reset bubble_ex", int'(bub1), 1);
    chk("reset ex_dest", int'(exd1), 0);
    chk("reset wb_dest", int'(wbd1), 0);
    chk("reset stall_if_id", int'(st1), 0);
    chk("reset stall_cycles", int'(sc1), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i], 0, i);
      if (i == 17 || i == 20) chk($sformatf("d0/%0d stall_cycles", i), int'(sc1), 1);
    end

    // LOAD_STALL=3: flush during the second STALL-state cycle ends the stall at once
    reset_pulse();
    step(mk(1,0,0,0,0, 2,1,1,0, 0, 0,0,0, 2,0), 1, 100);
    step(mk(1,2,1,0,0, 5,1,0,0, 1, 0,0,1, 0,2), 1, 101);
    chk("d1/101 stall_cycles", int'(sc3), 1);
    step(mk(1,2,1,0,0, 5,1,0,0, 1, 0,0,1, 0,0), 1, 102);
    step(mk(1,2,1,0,0, 5,1,0,1, 0, 0,0,1, 0,0), 1, 103);
    chk("d1/103 stall_cycles", int'(sc3), 2);
    step(mk(1,2,1,0,0, 5,1,0,0, 0, 0,0,0, 5,0), 1, 104);

    // Full three-cycle stall with both operands hitting the same load
    step(mk(1,0,0,0,0, 3,1,1,0, 0, 0,0,0, 3,5), 1, 105);
    step(mk(1,3,1,3,1, 6,1,0,0, 1, 0,0,1, 0,3), 1, 106);
    step(mk(1,3,1,3,1, 6,1,0,0, 1, 0,0,1, 0,0), 1, 107);
    step(mk(1,3,1,3,1, 6,1,0,0, 1, 0,0,1, 0,0), 1, 108);
    step(mk(1,3,1,3,1, 6,1,0,0, 0, 0,0,0, 6,0), 1, 109);
    chk("d1/109 stall_cycles", int'(sc3), 5);

    // Asynchronous reset mid-stall
    step(mk(1,0,0,0,0, 1,1,1,0, 0, 0,0,0, 1,6), 1, 110);
    step(mk(1,1,1,0,0, 4,1,0,0, 1, 0,0,1, 0,1), 1, 111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async stall_if_id", int'(st3), 0);
    chk("async bubble_ex", int'(bub3), 1);
    chk("async fwd_sel_a", int'(fa3), 0);
    chk("async ex_dest", int'(exd3), 0);
    chk("async wb_dest", int'(wbd3), 0);
    chk("async stall_cycles", int'(sc3), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(1,1,1,0,0, 4,1,0,0, 0, 0,0,0, 4,0), 1, 112);
    chk("d1/112 stall_cycles", int'(sc3), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
